// File: rtl/camera_window_capture.sv
// Camera pixel-clock write path: pairs camera bytes into 16-bit pixels, crops
// a window with optional power-of-two decimation, and streams the kept pixels
// linearly into a frame RAM under a single-shot / continuous capture handshake.
//
// Ports:
//   clk, reset          pixel clock, asynchronous active-high reset
//   href, vref          line valid, frame sync (high = vertical blank)
//   digital[7:0]        camera data byte
//   capture             one-cycle start request (ignored while busy)
//   continuous          re-arm automatically after every frame
//   pixel[15:0]         assembled pixel, valid with wren
//   wraddr[ADDR_W-1:0]  RAM write address, valid with wren
//   wren                one-cycle write strobe
//   busy                high while armed or capturing
//   frame_done          one-cycle pulse at the end of a captured frame
//   x[10:0], y[10:0]    current source column / line
module camera_window_capture #(
    parameter int unsigned HSTART    = 0,
    parameter int unsigned VSTART    = 0,
    parameter int unsigned WIDTH     = 120,
    parameter int unsigned HEIGHT    = 120,
    parameter int unsigned XDEC_LOG2 = 0,
    parameter int unsigned YDEC_LOG2 = 0,
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned BYTE_SWAP = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              href,
    input  logic              vref,
    input  logic [7:0]        digital,
    input  logic              capture,
    input  logic              continuous,
    output logic [15:0]       pixel,
    output logic [ADDR_W-1:0] wraddr,
    output logic              wren,
    output logic              busy,
    output logic              frame_done,
    output logic [10:0]       x,
    output logic [10:0]       y
);

    localparam int unsigned CNT_W     = ADDR_W + 1;
    localparam int unsigned COORD_MAX = 2047;
    localparam int unsigned XDEC_MASK = (32'd1 << XDEC_LOG2) - 32'd1;
    localparam int unsigned YDEC_MASK = (32'd1 << YDEC_LOG2) - 32'd1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic             href_d;
    logic             vref_d;
    logic             phase;
    logic [7:0]       byte_hold;
    logic             first_seen;
    // Write counter carries one extra bit so a full RAM stops writes instead of wrapping.
    logic [CNT_W-1:0] wr_cnt;

    logic             href_rise_c;
    logic             vref_rise_c;
    logic             take_c;
    logic             pix_done_c;
    logic [15:0]      pix_c;
    logic [31:0]      dx_c;
    logic [31:0]      dy_c;
    logic             in_win_c;
    logic             start_c;
    logic             done_c;
    logic             wr_c;

    // Input edge detection and byte qualification.
    always_comb begin
        href_rise_c = href & ~href_d;
        vref_rise_c = vref & ~vref_d;
        take_c      = href & ~vref;
        pix_done_c  = take_c & phase & ~href_rise_c;
        pix_c       = (BYTE_SWAP != 0) ? {digital, byte_hold} : {byte_hold, digital};
    end

    // Window and decimation test; x < HSTART wraps dx_c to a huge value and fails the width test.
    always_comb begin
        dx_c     = 32'(x) - HSTART;
        dy_c     = 32'(y) - VSTART;
        in_win_c = (dx_c < WIDTH) && (dy_c < HEIGHT) &&
                   ((dx_c & XDEC_MASK) == 32'd0) && ((dy_c & YDEC_MASK) == 32'd0);
    end

    // Edge detector history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            href_d <= 1'b0;
            vref_d <= 1'b0;
        end else begin
            href_d <= href;
            vref_d <= vref;
        end
    end

    // Byte pairing; the phase restarts on every line so a dangling odd byte is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase     <= 1'b0;
            byte_hold <= 8'd0;
        end else if (take_c) begin
            if (href_rise_c || !phase) begin
                byte_hold <= digital;
                phase     <= 1'b1;
            end else begin
                phase     <= 1'b0;
            end
        end else begin
            phase <= 1'b0;
        end
    end

    // Source coordinates: blanking clears, first line after blanking is y=0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x          <= 11'd0;
            y          <= 11'd0;
            first_seen <= 1'b0;
        end else if (vref) begin
            x          <= 11'd0;
            y          <= 11'd0;
            first_seen <= 1'b0;
        end else if (href_rise_c) begin
            x <= 11'd0;
            if (!first_seen) begin
                y          <= 11'd0;
                first_seen <= 1'b1;
            end else if (y != 11'(COORD_MAX)) begin
                y <= y + 11'd1;
            end
        end else if (pix_done_c && (x != 11'(COORD_MAX))) begin
            x <= x + 11'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // FSM next state; continuous mode goes straight back to capturing on the closing edge.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (capture) state_nxt = ST_ARM;
            ST_ARM:     if (vref_rise_c) state_nxt = ST_CAPTURE;
            ST_CAPTURE: if (vref_rise_c) state_nxt = continuous ? ST_CAPTURE : ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // FSM control decode.
    always_comb begin
        start_c = 1'b0;
        done_c  = 1'b0;
        wr_c    = 1'b0;
        case (state)
            ST_ARM: start_c = vref_rise_c;
            ST_CAPTURE: begin
                done_c  = vref_rise_c;
                start_c = vref_rise_c & continuous;
                wr_c    = pix_done_c & in_win_c & ~wr_cnt[ADDR_W];
            end
            default: ;
        endcase
    end

    // Registered outputs and write address counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel      <= 16'd0;
            wraddr     <= '0;
            wren       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            wr_cnt     <= '0;
        end else begin
            wren       <= wr_c;
            frame_done <= done_c;
            busy       <= (state_nxt != ST_IDLE);
            if (start_c) begin
                wr_cnt <= '0;
                wraddr <= '0;
            end else if (wr_c) begin
                pixel  <= pix_c;
                wraddr <= wr_cnt[ADDR_W-1:0];
                wr_cnt <= wr_cnt + CNT_W'(1);
            end
        end
    end

endmodule
